// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch port, the data port and the shared memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              mm_req;
    logic              mm_we;
    logic [ADDR_W-1:0] mm_addr;
    logic [DATA_W-1:0] mm_wdata;
    logic              mm_ack;
    logic [DATA_W-1:0] mm_rdata;
    logic              mm_busy;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_ack, if_rdata,
        input  mm_req, mm_we, mm_addr, mm_wdata,
        output mm_ack, mm_rdata, mm_busy,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_ack, if_rdata,
        output mm_req, mm_we, mm_addr, mm_wdata,
        input  mm_ack, mm_rdata, mm_busy,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: data port normally wins, fetch port is guaranteed
// a grant after three consecutive contended data grants.
module mem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MM, DONE} state_e;

    state_e            state_q, state_d;
    logic              owner_mm_q, owner_mm_d;
    logic [1:0]        streak_q, streak_d;
    logic              drop_q, drop_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              mm_ack_q, mm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mm_rdata_q, mm_rdata_d;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_mm_q  <= 1'b0;
            streak_q    <= 2'd0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            mm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_mm_q  <= owner_mm_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            mm_ack_q    <= mm_ack_d;
            if_rdata_q  <= if_rdata_d;
            mm_rdata_q  <= mm_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_mm_d  = owner_mm_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        mm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        mm_rdata_d  = mm_rdata_q;

        case (state_q)
            IDLE: begin
                // Fetch only overrides a pending data request once the streak saturates.
                if (bus.mm_req && !(bus.if_req && streak_q == 2'd3)) begin
                    state_d     = GNT_MM;
                    owner_mm_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.mm_we;
                    mem_addr_d  = bus.mm_addr;
                    mem_wdata_d = bus.mm_wdata;
                    streak_d    = bus.if_req ? sat_inc(streak_q) : 2'd0;
                end else if (bus.if_req) begin
                    state_d     = GNT_IF;
                    owner_mm_d  = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    streak_d    = 2'd0;
                end
            end
            GNT_IF: begin
                drop_d = drop_q | bus.if_flush;
                if (bus.mem_ready) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = bus.mem_rdata;
                    if_ack_d   = !(drop_q || bus.if_flush);
                end
            end
            GNT_MM: begin
                if (bus.mem_ready) begin
                    state_d  = DONE;
                    mem_req_d = 1'b0;
                    mm_ack_d = 1'b1;
                    // Stores leave the last load value visible.
                    if (!mem_we_q) mm_rdata_d = bus.mem_rdata;
                end
            end
            DONE: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mm_ack    = mm_ack_q;
    assign bus.mm_rdata  = mm_rdata_q;
    assign bus.mm_busy   = bus.mm_req && !(state_q == DONE && owner_mm_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/load, contention order,
// flush suppression and reset mid-transaction.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   bus.mem_req,   32'h0);
        chk({tag, "_mem_we"},    bus.mem_we,    32'h0);
        chk({tag, "_mem_addr"},  bus.mem_addr,  32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_if_ack"},    bus.if_ack,    32'h0);
        chk({tag, "_mm_ack"},    bus.mm_ack,    32'h0);
        chk({tag, "_if_rdata"},  bus.if_rdata,  32'h0);
        chk({tag, "_mm_rdata"},  bus.mm_rdata,  32'h0);
    endtask

    logic exp_mm [8];

    initial begin
        checks = 0;
        errors = 0;
        exp_mm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.mm_req = 1'b0; bus.mm_we = 1'b0; bus.mm_addr = '0; bus.mm_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        step();
        step();
        chk_reset_outputs("rst");
        chk("rst_busy", bus.mm_busy, 32'h0);
        rst = 1'b0;
        step();

        // Single fetch, memory ready two cycles after mem_req
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        step();
        chk("f_mem_req", bus.mem_req, 32'h1);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_we", bus.mem_we, 32'h0);
        chk("f_busy0", bus.mm_busy, 32'h0);
        step();
        chk("f_hold_req", bus.mem_req, 32'h1);
        chk("f_no_ack", bus.if_ack, 32'h0);
        step();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        step();
        chk("f_ack", bus.if_ack, 32'h1);
        chk("f_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("f_req_drop", bus.mem_req, 32'h0);
        chk("f_busy1", bus.mm_busy, 32'h0);
        bus.mem_ready = 1'b0; bus.if_req = 1'b0;
        step();
        chk("f_ack_pulse", bus.if_ack, 32'h0);
        chk("f_rdata_keep", bus.if_rdata, 32'hDEADBEEF);

        // Store
        bus.mm_req = 1'b1; bus.mm_we = 1'b1; bus.mm_addr = 32'h2000; bus.mm_wdata = 32'h12345678;
        #1;
        chk("s_busy_idle", bus.mm_busy, 32'h1);
        step();
        chk("s_mem_req", bus.mem_req, 32'h1);
        chk("s_mem_we", bus.mem_we, 32'h1);
        chk("s_mem_addr", bus.mem_addr, 32'h2000);
        chk("s_mem_wdata", bus.mem_wdata, 32'h12345678);
        chk("s_busy_gnt", bus.mm_busy, 32'h1);
        step();
        chk("s_hold_we", bus.mem_we, 32'h1);
        chk("s_hold_wdata", bus.mem_wdata, 32'h12345678);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hAAAA5555;
        step();
        chk("s_ack", bus.mm_ack, 32'h1);
        chk("s_busy_done", bus.mm_busy, 32'h0);
        chk("s_rdata_unch", bus.mm_rdata, 32'h0);
        bus.mem_ready = 1'b0; bus.mm_req = 1'b0; bus.mm_we = 1'b0;
        step();
        chk("s_ack_pulse", bus.mm_ack, 32'h0);

        // Load at minimum latency, with a flush that must not affect the data port
        bus.mm_req = 1'b1; bus.mm_addr = 32'h3000;
        step();
        chk("l_mem_addr", bus.mem_addr, 32'h3000);
        chk("l_mem_we", bus.mem_we, 32'h0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D; bus.if_flush = 1'b1;
        step();
        chk("l_ack", bus.mm_ack, 32'h1);
        chk("l_rdata", bus.mm_rdata, 32'hCAFEF00D);
        bus.mem_ready = 1'b0; bus.mm_req = 1'b0; bus.if_flush = 1'b0;
        step();

        // Contention: both ports request continuously
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.mm_req = 1'b1; bus.mm_addr = 32'h20;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("c%0d_addr", i), bus.mem_addr, exp_mm[i] ? 32'h20 : 32'h10);
            chk($sformatf("c%0d_req", i), bus.mem_req, 32'h1);
            bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA0 + i;
            step();
            bus.mem_ready = 1'b0;
            chk($sformatf("c%0d_mm_ack", i), bus.mm_ack, {31'b0, exp_mm[i]});
            chk($sformatf("c%0d_if_ack", i), bus.if_ack, {31'b0, !exp_mm[i]});
            chk($sformatf("c%0d_rdata", i), exp_mm[i] ? bus.mm_rdata : bus.if_rdata, 32'hA0 + i);
            chk($sformatf("c%0d_busy", i), bus.mm_busy, {31'b0, !exp_mm[i]});
            step();
            chk($sformatf("c%0d_no_gnt_done", i), bus.mem_req, 32'h0);
        end
        bus.if_req = 1'b0; bus.mm_req = 1'b0;
        step();

        // Flush during GNT_IF at 0x40
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        step();
        chk("fl_addr", bus.mem_addr, 32'h40);
        bus.if_flush = 1'b1;
        step();
        bus.if_flush = 1'b0;
        chk("fl_hold_req", bus.mem_req, 32'h1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11111111;
        step();
        chk("fl_no_ack", bus.if_ack, 32'h0);
        chk("fl_req_drop", bus.mem_req, 32'h0);
        bus.mem_ready = 1'b0; bus.if_addr = 32'h80;
        step();
        chk("fl_no_ack2", bus.if_ack, 32'h0);
        step();
        chk("fl2_addr", bus.mem_addr, 32'h80);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h80808080;
        step();
        chk("fl2_ack", bus.if_ack, 32'h1);
        chk("fl2_rdata", bus.if_rdata, 32'h80808080);
        bus.mem_ready = 1'b0; bus.if_addr = 32'h44;
        step();

        // Flush on the GNT_IF->DONE edge
        step();
        chk("fe_addr", bus.mem_addr, 32'h44);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h44444444; bus.if_flush = 1'b1;
        step();
        chk("fe_no_ack", bus.if_ack, 32'h0);
        bus.mem_ready = 1'b0; bus.if_flush = 1'b0; bus.if_req = 1'b0;
        step();

        // Reset during GNT_MM, then a stray mem_ready
        bus.mm_req = 1'b1; bus.mm_addr = 32'h500;
        step();
        chk("r_mem_req", bus.mem_req, 32'h1);
        chk("r_mem_addr", bus.mem_addr, 32'h500);
        rst = 1'b1; bus.mm_req = 1'b0;
        step();
        chk_reset_outputs("rmid");
        rst = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
        step();
        chk("r_no_ack", bus.mm_ack, 32'h0);
        chk("r_no_req", bus.mem_req, 32'h0);
        bus.mem_ready = 1'b0;
        step();
        chk_reset_outputs("rpost");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
